// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multiply/divide unit for the execute stage. Owns the HI/LO
//               register pair. Multiply and divide results are computed when
//               the op is sampled, held in pending registers, and committed
//               to HI/LO after a fixed, parameterised busy period.
// Ports       : clk     - rising-edge clock
//               reset   - asynchronous active-low reset
//               mduOp   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                         6 mflo, 7 mthi, 8 mtlo, 9..15 none
//               srcA    - rs operand (dividend / multiplicand / mthi-mtlo data)
//               srcB    - rt operand (divisor / multiplier)
//               busy    - high while a multiply/divide is in flight
//               hi, lo  - architectural HI/LO registers
//               rdData  - combinational mfhi/mflo read data, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mduOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdData
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_phi;
    logic [31:0]        r_plo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_start;
    logic               w_ovf;
    logic [31:0]        w_divisor;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    assign w_is_mul = (mduOp == c_OP_MULT) || (mduOp == c_OP_MULTU);
    assign w_is_div = (mduOp == c_OP_DIV)  || (mduOp == c_OP_DIVU);
    // A zero divisor never starts a busy phase and leaves HI/LO untouched.
    assign w_start  = (r_state == c_ST_IDLE) &&
                      (w_is_mul || (w_is_div && (srcB != 32'd0)));

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    assign w_prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};

    // Divisor is forced to 1 when it is zero so the divider output is always
    // defined (the result is discarded anyway). For the signed overflow case
    // 0x80000000 / -1, dividing by 1 instead yields exactly the required
    // quotient 0x80000000 and remainder 0, so no extra result mux is needed.
    assign w_ovf     = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
    assign w_divisor = (srcB == 32'd0) ? 32'd1 : srcB;
    assign w_sa      = $signed(srcA);
    assign w_sb      = w_ovf ? 32'sd1 : $signed(w_divisor);
    assign w_q_s     = w_sa / w_sb;
    assign w_r_s     = w_sa % w_sb;
    assign w_q_u     = srcA / w_divisor;
    assign w_r_u     = srcA % w_divisor;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (mduOp)
            c_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            c_OP_DIV: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
            end
            c_OP_DIVU: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start)             w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (r_cnt == c_CNT_ONE)  w_state_nxt = c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == c_ST_RUN);
    end

    // ------------------------------------------------------------------
    // Datapath registers: counter, pending result, HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_phi <= 32'd0;
            r_plo <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_start) begin
                r_phi <= w_res_hi;
                r_plo <= w_res_lo;
                r_cnt <= w_is_mul ? c_CNT_MULT : c_CNT_DIV;
            end else if (mduOp == c_OP_MTHI) begin
                r_hi <= srcA;
            end else if (mduOp == c_OP_MTLO) begin
                r_lo <= srcA;
            end
        end else begin
            // In RUN every incoming op is ignored; only the countdown runs.
            if (r_cnt == c_CNT_ONE) begin
                r_hi  <= r_phi;
                r_lo  <= r_plo;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

    always_comb begin
        rdData = 32'd0;
        if (mduOp == c_OP_MFHI) begin
            rdData = r_hi;
        end else if (mduOp == c_OP_MFLO) begin
            rdData = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit. A behavioural model tracks
//               HI/LO and the remaining busy cycles with plain arithmetic;
//               directed scenarios are followed by randomized op streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  mduOp = 4'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdData;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    int          m_left = 0;

    mdu_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .mduOp  (mduOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rdData (rdData)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Model of one rising edge with the given op presented.
    task automatic model_edge(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        longint      ps;
        logic [63:0] pu;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                4'd1: begin
                    ps = sa * sb;
                    m_phi = ps[63:32];
                    m_plo = ps[31:0];
                    m_left = MULT_CYCLES;
                end
                4'd2: begin
                    pu = {32'd0, a} * {32'd0, b};
                    m_phi = pu[63:32];
                    m_plo = pu[31:0];
                    m_left = MULT_CYCLES;
                end
                4'd3: if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_phi = r[31:0];
                    m_plo = q[31:0];
                    m_left = DIV_CYCLES;
                end
                4'd4: if (b != 32'd0) begin
                    m_phi = a % b;
                    m_plo = a / b;
                    m_left = DIV_CYCLES;
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // Called 1 time unit after a rising edge. Presents an op, checks rdData,
    // clocks it in and checks busy/hi/lo against the model.
    task automatic step(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag,
                        output logic [31:0] rd);
        logic [31:0] exp_rd;
        mduOp = op;
        srcA  = a;
        srcB  = b;
        #1;
        exp_rd = (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'd0);
        rd = rdData;
        check_value({tag, ".rdData"}, rdData, exp_rd);
        @(posedge clk);
        model_edge(op, a, b);
        #1;
        check_value({tag, ".busy"}, busy, (m_left > 0));
        check_value({tag, ".hi"}, hi, m_hi);
        check_value({tag, ".lo"}, lo, m_lo);
    endtask

    // Issue an op and idle until busy drops, returning the busy cycle count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag,
                          output int busy_cycles);
        logic [31:0] rd;
        int          guard;
        busy_cycles = 0;
        guard = 0;
        step(op, a, b, tag, rd);
        while (busy && guard < 50) begin
            busy_cycles++;
            guard++;
            step(4'd0, 32'd0, 32'd0, tag, rd);
        end
        if (guard >= 50) check_value({tag, ".timeout"}, 1, 0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        int          nb;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("reset.busy", busy, 0);
        check_value("reset.hi", hi, 0);
        check_value("reset.lo", lo, 0);
        reset = 1'b1;

        // multiply
        run_op(4'd1, 32'hFFFF_FFFF, 32'h2, "mult", nb);
        check_value("mult.cycles", nb, MULT_CYCLES);
        check_value("mult.hi_tp", hi, 32'hFFFF_FFFF);
        check_value("mult.lo_tp", lo, 32'hFFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'h2, "multu", nb);
        check_value("multu.hi_tp", hi, 32'h1);
        check_value("multu.lo_tp", lo, 32'hFFFF_FFFE);

        // divide
        run_op(4'd3, 32'hFFFF_FFF9, 32'h2, "div", nb);
        check_value("div.cycles", nb, DIV_CYCLES);
        check_value("div.lo_tp", lo, 32'hFFFF_FFFD);
        check_value("div.hi_tp", hi, 32'hFFFF_FFFF);
        run_op(4'd4, 32'hFFFF_FFF9, 32'h2, "divu", nb);
        check_value("divu.lo_tp", lo, 32'h7FFF_FFFC);
        check_value("divu.hi_tp", hi, 32'h1);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf", nb);
        check_value("divovf.lo_tp", lo, 32'h8000_0000);
        check_value("divovf.hi_tp", hi, 32'h0);

        // move to / from HI/LO
        step(4'd7, 32'h1234_5678, 32'd0, "mthi", rd);
        check_value("mthi.hi_tp", hi, 32'h1234_5678);
        step(4'd8, 32'h9ABC_DEF0, 32'd0, "mtlo", rd);
        check_value("mtlo.lo_tp", lo, 32'h9ABC_DEF0);
        step(4'd5, 32'd0, 32'd0, "mfhi", rd);
        check_value("mfhi.rd_tp", rd, 32'h1234_5678);
        step(4'd6, 32'd0, 32'd0, "mflo", rd);
        check_value("mflo.rd_tp", rd, 32'h9ABC_DEF0);

        // divide by zero
        step(4'd7, 32'h11, 32'd0, "preset_hi", rd);
        step(4'd8, 32'h22, 32'd0, "preset_lo", rd);
        step(4'd3, 32'd5, 32'd0, "divzero", rd);
        check_value("divzero.busy_tp", busy, 0);
        step(4'd4, 32'd9, 32'd0, "divuzero", rd);
        check_value("divzero.hi_tp", hi, 32'h11);
        check_value("divzero.lo_tp", lo, 32'h22);

        // ops during RUN are ignored
        step(4'd1, 32'd3, 32'd4, "ign", rd);
        step(4'd0, 32'd0, 32'd0, "ign", rd);
        step(4'd8, 32'hDEAD, 32'd0, "ign", rd);
        step(4'd2, 32'd7, 32'd7, "ign", rd);
        step(4'd0, 32'd0, 32'd0, "ign", rd);
        step(4'd0, 32'd0, 32'd0, "ign", rd);
        check_value("ign.busy_tp", busy, 0);
        check_value("ign.hi_tp", hi, 32'h0);
        check_value("ign.lo_tp", lo, 32'hC);

        // new op on the edge where busy falls is ignored
        step(4'd1, 32'd2, 32'd3, "edge", rd);
        repeat (MULT_CYCLES - 1) step(4'd0, 32'd0, 32'd0, "edge", rd);
        step(4'd2, 32'd5, 32'd5, "edge", rd);
        check_value("edge.busy_tp", busy, 0);
        check_value("edge.lo_tp", lo, 32'd6);

        // asynchronous reset mid-RUN
        step(4'd3, 32'd100, 32'd7, "rst", rd);
        repeat (3) step(4'd0, 32'd0, 32'd0, "rst", rd);
        #2;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_left = 0;
        #1;
        check_value("rst.busy_async", busy, 0);
        check_value("rst.hi_async", hi, 0);
        check_value("rst.lo_async", lo, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (DIV_CYCLES + 2) step(4'd0, 32'd0, 32'd0, "rst_after", rd);
        check_value("rst_after.hi_tp", hi, 0);
        check_value("rst_after.lo_tp", lo, 0);

        // randomized op stream, including ops issued while busy
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 8));
            a  = rand_operand();
            b  = rand_operand();
            step(op, a, b, "rand", rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
